// File: rtl/sd_sector_buffer.sv
// Purpose: capture one 512-byte sector from the SD read stream into BRAM, with count/checksum/first byte.
// Latency: stream byte written on the edge it is valid; readback buf_rdata is 1 cycle after buf_raddr.
// Backpressure: none; the stream cannot be stalled, bytes beyond DEPTH are dropped and flagged.
module sd_sector_buffer #(
   parameter int DEPTH = 512,
   parameter int AW    = 9,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cap_start,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   input  logic          in_done,
   input  logic [AW-1:0] buf_raddr,
   output logic [DW-1:0] buf_rdata,
   output logic          cap_busy,
   output logic          cap_ready,
   output logic          cap_err,
   output logic [AW:0]   byte_cnt,
   output logic [15:0]   checksum,
   output logic [DW-1:0] first_byte
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2,
      ST_ERROR   = 2'd3
   } state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic          ovf_q;
   logic          full;
   logic          accept;
   logic          drop;
   logic [AW:0]   cnt_inc;
   logic [AW:0]   cnt_final;
   logic          ovf_final;

   logic [DW-1:0] mem [DEPTH];

   // Stream qualification; a restart pulse swallows any byte or done in its cycle.
   always_comb begin
      full      = (byte_cnt == FULL_CNT);
      accept    = (state_q == ST_CAPTURE) && in_valid && !cap_start && !full;
      drop      = (state_q == ST_CAPTURE) && in_valid && !cap_start && full;
      cnt_inc   = byte_cnt + (AW+1)'(1);
      cnt_final = accept ? cnt_inc : byte_cnt;
      ovf_final = ovf_q | drop;
   end

   // Next-state logic; the completion check includes a byte arriving with in_done.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (cap_start) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (cap_start) begin
               state_d = ST_CAPTURE;
            end else if (in_done) begin
               if ((cnt_final == FULL_CNT) && !ovf_final) state_d = ST_DONE;
               else                                       state_d = ST_ERROR;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Status flags decode the state flop, so they move on the state-changing edge.
   always_comb begin
      cap_busy  = (state_q == ST_CAPTURE);
      cap_ready = (state_q == ST_DONE);
      cap_err   = (state_q == ST_ERROR);
   end

   // Capture statistics; cleared by cap_start, held after completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt   <= '0;
         checksum   <= '0;
         first_byte <= '0;
         ovf_q      <= 1'b0;
      end else if (cap_start) begin
         byte_cnt   <= '0;
         checksum   <= '0;
         first_byte <= '0;
         ovf_q      <= 1'b0;
      end else begin
         if (accept) begin
            byte_cnt <= cnt_inc;
            checksum <= checksum + 16'(in_data);
            if (byte_cnt == '0) first_byte <= in_data;
         end
         if (drop) ovf_q <= 1'b1;
      end
   end

   // Sector RAM write port; no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (accept) mem[byte_cnt[AW-1:0]] <= in_data;
   end

   // Registered read port; read-first on a same-address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) buf_rdata <= '0;
      else     buf_rdata <= mem[buf_raddr];
   end

endmodule

// File: tb/tb_sd_sector_buffer.sv
module tb_sd_sector_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cap_start;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_done;
   logic [8:0] buf_raddr;
   logic [7:0] buf_rdata;
   logic       cap_busy;
   logic       cap_ready;
   logic       cap_err;
   logic [9:0] byte_cnt;
   logic [15:0] checksum;
   logic [7:0] first_byte;

   int total = 0;
   int bad   = 0;

   sd_sector_buffer #(.DEPTH(512), .AW(9), .DW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .cap_start  (cap_start),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_done    (in_done),
      .buf_raddr  (buf_raddr),
      .buf_rdata  (buf_rdata),
      .cap_busy   (cap_busy),
      .cap_ready  (cap_ready),
      .cap_err    (cap_err),
      .byte_cnt   (byte_cnt),
      .checksum   (checksum),
      .first_byte (first_byte)
   );

   always #5 clk = ~clk;

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      cap_start = 1'b1;
      tick();
      cap_start = 1'b0;
   endtask

   task automatic pulse_done();
      in_done = 1'b1;
      tick();
      in_done = 1'b0;
   endtask

   // n bytes, data = base + i when incr, else constant base; gap idle cycles after each.
   task automatic send_bytes(input int n, input logic [7:0] base, input bit incr, input int gap);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = incr ? 8'(base + i) : base;
         tick();
         in_valid = 1'b0;
         repeat (gap) tick();
      end
   endtask

   task automatic read_byte(input logic [8:0] a);
      buf_raddr = a;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; cap_start = 0; in_data = 0; in_valid = 0; in_done = 0; buf_raddr = 0;
      #12;
      total++; if (cap_busy !== 1'b0)  begin bad++; $display("FAIL rst_busy got=%b exp=0", cap_busy); end
      total++; if (cap_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", cap_ready); end
      total++; if (cap_err !== 1'b0)   begin bad++; $display("FAIL rst_err got=%b exp=0", cap_err); end
      total++; if (byte_cnt !== 10'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", byte_cnt); end
      total++; if (checksum !== 16'h0) begin bad++; $display("FAIL rst_sum got=%h exp=0000", checksum); end
      total++; if (buf_rdata !== 8'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=00", buf_rdata); end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_full_sector();
      pulse_start();
      total++; if (cap_busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%b exp=1", cap_busy); end
      send_bytes(512, 8'h00, 1'b1, 3);
      total++; if (cap_ready !== 1'b0) begin bad++; $display("FAIL t1_early_ready got=%b exp=0", cap_ready); end
      pulse_done();
      total++; if (cap_ready !== 1'b1) begin bad++; $display("FAIL t1_ready got=%b exp=1", cap_ready); end
      total++; if (cap_busy !== 1'b0)  begin bad++; $display("FAIL t1_busy_off got=%b exp=0", cap_busy); end
      total++; if (byte_cnt !== 10'd512) begin bad++; $display("FAIL t1_cnt got=%0d exp=512", byte_cnt); end
      total++; if (checksum !== 16'hFF00) begin bad++; $display("FAIL t1_sum got=%h exp=ff00", checksum); end
      total++; if (first_byte !== 8'h00) begin bad++; $display("FAIL t1_first got=%h exp=00", first_byte); end
      read_byte(9'h1FF);
      total++; if (buf_rdata !== 8'hFF) begin bad++; $display("FAIL t1_rd1ff got=%h exp=ff", buf_rdata); end
      read_byte(9'h081);
      total++; if (buf_rdata !== 8'h81) begin bad++; $display("FAIL t1_rd081 got=%h exp=81", buf_rdata); end
      // Stray stream activity in DONE must not disturb anything.
      in_valid = 1'b1; in_data = 8'h5A; in_done = 1'b1; tick(); in_valid = 1'b0; in_done = 1'b0;
      total++; if (cap_ready !== 1'b1 || byte_cnt !== 10'd512) begin bad++; $display("FAIL t1_hold got=%b/%0d exp=1/512", cap_ready, byte_cnt); end
   endtask

   task automatic test_short();
      pulse_start();
      total++; if (cap_ready !== 1'b0 || byte_cnt !== 10'd0) begin bad++; $display("FAIL t2_clear got=%b/%0d exp=0/0", cap_ready, byte_cnt); end
      send_bytes(300, 8'h33, 1'b0, 0);
      pulse_done();
      total++; if (cap_err !== 1'b1)   begin bad++; $display("FAIL t2_err got=%b exp=1", cap_err); end
      total++; if (cap_ready !== 1'b0) begin bad++; $display("FAIL t2_ready got=%b exp=0", cap_ready); end
      total++; if (byte_cnt !== 10'd300) begin bad++; $display("FAIL t2_cnt got=%0d exp=300", byte_cnt); end
      total++; if (checksum !== 16'h3BC4) begin bad++; $display("FAIL t2_sum got=%h exp=3bc4", checksum); end
      total++; if (first_byte !== 8'h33) begin bad++; $display("FAIL t2_first got=%h exp=33", first_byte); end
   endtask

   task automatic test_overlong();
      pulse_start();
      total++; if (cap_err !== 1'b0) begin bad++; $display("FAIL t3_errclr got=%b exp=0", cap_err); end
      send_bytes(512, 8'h01, 1'b0, 0);
      // 513th byte uses a distinct value so a wrongful write to index 0 would show.
      send_bytes(1, 8'hEE, 1'b0, 0);
      pulse_done();
      total++; if (cap_err !== 1'b1) begin bad++; $display("FAIL t3_err got=%b exp=1", cap_err); end
      total++; if (byte_cnt !== 10'd512) begin bad++; $display("FAIL t3_cnt got=%0d exp=512", byte_cnt); end
      total++; if (checksum !== 16'h0200) begin bad++; $display("FAIL t3_sum got=%h exp=0200", checksum); end
      read_byte(9'h000);
      total++; if (buf_rdata !== 8'h01) begin bad++; $display("FAIL t3_rd000 got=%h exp=01", buf_rdata); end
      read_byte(9'h1FF);
      total++; if (buf_rdata !== 8'h01) begin bad++; $display("FAIL t3_rd1ff got=%h exp=01", buf_rdata); end
   endtask

   task automatic test_valid_with_done();
      pulse_start();
      send_bytes(511, 8'h02, 1'b0, 0);
      in_valid = 1'b1; in_data = 8'h39; in_done = 1'b1;
      tick();
      in_valid = 1'b0; in_done = 1'b0;
      total++; if (cap_ready !== 1'b1) begin bad++; $display("FAIL t4_ready got=%b exp=1", cap_ready); end
      total++; if (byte_cnt !== 10'd512) begin bad++; $display("FAIL t4_cnt got=%0d exp=512", byte_cnt); end
      total++; if (checksum !== 16'h0437) begin bad++; $display("FAIL t4_sum got=%h exp=0437", checksum); end
      read_byte(9'h1FF);
      total++; if (buf_rdata !== 8'h39) begin bad++; $display("FAIL t4_rd1ff got=%h exp=39", buf_rdata); end
   endtask

   task automatic test_restart();
      pulse_start();
      // Read-first: address 0 holds 02 from the previous sector while 55 is written.
      buf_raddr = 9'h000; in_valid = 1'b1; in_data = 8'h55;
      tick();
      in_valid = 1'b0;
      total++; if (buf_rdata !== 8'h02) begin bad++; $display("FAIL t5_readfirst got=%h exp=02", buf_rdata); end
      tick();
      total++; if (buf_rdata !== 8'h55) begin bad++; $display("FAIL t5_newdata got=%h exp=55", buf_rdata); end
      send_bytes(99, 8'h55, 1'b0, 0);
      total++; if (byte_cnt !== 10'd100) begin bad++; $display("FAIL t5_partial got=%0d exp=100", byte_cnt); end
      // Restart with a byte in the same cycle: the byte is lost.
      cap_start = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
      tick();
      cap_start = 1'b0; in_valid = 1'b0;
      total++; if (cap_busy !== 1'b1 || byte_cnt !== 10'd0 || checksum !== 16'h0) begin bad++; $display("FAIL t5_restart got=%b/%0d/%h exp=1/0/0000", cap_busy, byte_cnt, checksum); end
      send_bytes(512, 8'h30, 1'b0, 0);
      pulse_done();
      total++; if (cap_ready !== 1'b1) begin bad++; $display("FAIL t5_ready got=%b exp=1", cap_ready); end
      total++; if (byte_cnt !== 10'd512) begin bad++; $display("FAIL t5_cnt got=%0d exp=512", byte_cnt); end
      total++; if (checksum !== 16'h6000) begin bad++; $display("FAIL t5_sum got=%h exp=6000", checksum); end
      total++; if (first_byte !== 8'h30) begin bad++; $display("FAIL t5_first got=%h exp=30", first_byte); end
   endtask

   task automatic test_async_reset();
      pulse_start();
      send_bytes(10, 8'h44, 1'b0, 0);
      read_byte(9'h003);
      total++; if (buf_rdata !== 8'h44) begin bad++; $display("FAIL t6_pre_rd got=%h exp=44", buf_rdata); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (cap_busy !== 1'b0) begin bad++; $display("FAIL t6_busy got=%b exp=0", cap_busy); end
      total++; if (byte_cnt !== 10'd0 || checksum !== 16'h0 || first_byte !== 8'h0) begin bad++; $display("FAIL t6_stats got=%0d/%h/%h exp=0/0000/00", byte_cnt, checksum, first_byte); end
      total++; if (buf_rdata !== 8'h00 || cap_ready !== 1'b0 || cap_err !== 1'b0) begin bad++; $display("FAIL t6_outs got=%h/%b/%b exp=00/0/0", buf_rdata, cap_ready, cap_err); end
      repeat (2) tick();
      @(negedge clk);
      rst = 1'b0;
      tick();
      send_bytes(3, 8'h12, 1'b0, 0);
      pulse_done();
      total++; if (cap_busy !== 1'b0 || cap_ready !== 1'b0 || cap_err !== 1'b0) begin bad++; $display("FAIL t6_idle got=%b%b%b exp=000", cap_busy, cap_ready, cap_err); end
      total++; if (byte_cnt !== 10'd0 || checksum !== 16'h0) begin bad++; $display("FAIL t6_ignored got=%0d/%h exp=0/0000", byte_cnt, checksum); end
   endtask

   initial begin
      test_reset();
      test_full_sector();
      test_short();
      test_overlong();
      test_valid_with_done();
      test_restart();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
